// File: rtl/useq_engine.sv
// useq_engine: microprogram sequencer for the Kalman datapath control fields.
// A host-writable program RAM is stepped by a PC; the current word's fields
// are presented on ctl_*. Supports STEP/WAIT/HALT/JUMP/LOOP/LDCNT/CALL/RET,
// abort, and a sticky error flag for call-stack overflow/underflow.
//
// Handshake: start is a level sampled on a clock edge and is accepted only
// when ready=1 and abort_i=0; ready falls the cycle after acceptance. done
// pulses for one cycle (together with ready rising) after HALT executes.
// continue_i is sampled on each edge while a WAIT word is current.
module useq_engine #(
    parameter  int PC_W        = 8,
    parameter  int A_W         = 5,
    parameter  int B_W         = 5,
    parameter  int CNT_W       = 8,
    parameter  int STACK_DEPTH = 4,
    localparam int IW          = A_W + B_W + 3 + 2 + 2 + PC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            continue_i,
    input  logic            abort_i,
    input  logic            rom_we,
    input  logic [PC_W-1:0] rom_waddr,
    input  logic [IW-1:0]   rom_wdata,
    output logic [A_W-1:0]  ctl_a,
    output logic [B_W-1:0]  ctl_b,
    output logic [2:0]      ctl_op,
    output logic [1:0]      ctl_d,
    output logic [1:0]      ctl_e,
    output logic            ready,
    output logic            done,
    output logic            err,
    output logic [PC_W-1:0] pc_dbg
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_STEP  = 3'd0;
    localparam logic [2:0] OP_WAIT  = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_JUMP  = 3'd3;
    localparam logic [2:0] OP_LOOP  = 3'd4;
    localparam logic [2:0] OP_LDCNT = 3'd5;
    localparam logic [2:0] OP_CALL  = 3'd6;
    localparam logic [2:0] OP_RET   = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    logic [SP_W-1:0]  sp;

    logic [IW-1:0]    mem   [2**PC_W];
    logic [PC_W-1:0]  stack [STACK_DEPTH];

    logic [IW-1:0]    instr;
    logic [A_W-1:0]   f_a;
    logic [B_W-1:0]   f_b;
    logic [2:0]       f_op;
    logic [1:0]       f_d;
    logic [1:0]       f_e;
    logic [PC_W-1:0]  f_imm;
    logic [PC_W-1:0]  pc_inc;
    logic             push_en;

    // Asynchronous read of the current word and field split.
    assign instr  = mem[pc];
    assign f_imm  = instr[PC_W-1:0];
    assign f_e    = instr[PC_W+1:PC_W];
    assign f_d    = instr[PC_W+3:PC_W+2];
    assign f_op   = instr[PC_W+6:PC_W+4];
    assign f_b    = instr[PC_W+7 +: B_W];
    assign f_a    = instr[PC_W+7+B_W +: A_W];
    assign pc_inc = pc + PC_ONE;
    assign pc_dbg = pc;

    // A CALL pushes only when running, not aborted, and the stack has room.
    assign push_en = (state == S_RUN) && !abort_i && (f_op == OP_CALL) && (sp != SP_FULL);

    // Control fields follow the current word in RUN and are forced to zero in IDLE.
    always_comb begin
        ctl_a  = '0;
        ctl_b  = '0;
        ctl_op = '0;
        ctl_d  = '0;
        ctl_e  = '0;
        if (state == S_RUN) begin
            ctl_a  = f_a;
            ctl_b  = f_b;
            ctl_op = f_op;
            ctl_d  = f_d;
            ctl_e  = f_e;
        end
    end

    // Program RAM: host writes land only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (rom_we && (state == S_IDLE)) begin
            mem[rom_waddr] <= rom_wdata;
        end
    end

    // Return-address stack storage; sp lives in the FSM block.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[sp[SP_W-1:0]] <= pc_inc;
        end
    end

    // Sequencer FSM: PC, loop counter, stack pointer and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            cnt   <= '0;
            sp    <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort_i) begin
                        state <= S_RUN;
                        pc    <= '0;
                        sp    <= '0;
                        err   <= 1'b0;
                        ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                        pc    <= '0;
                        sp    <= '0;
                        ready <= 1'b1;
                    end else begin
                        case (f_op)
                            OP_STEP: pc <= pc_inc;
                            OP_WAIT: begin
                                if (continue_i) pc <= pc_inc;
                            end
                            OP_HALT: begin
                                state <= S_IDLE;
                                pc    <= '0;
                                sp    <= '0;
                                done  <= 1'b1;
                                ready <= 1'b1;
                            end
                            OP_JUMP: pc <= f_imm;
                            OP_LOOP: begin
                                if (cnt != '0) begin
                                    cnt <= cnt - CNT_ONE;
                                    pc  <= f_imm;
                                end else begin
                                    pc <= pc_inc;
                                end
                            end
                            OP_LDCNT: begin
                                cnt <= CNT_W'(f_imm);
                                pc  <= pc_inc;
                            end
                            OP_CALL: begin
                                if (sp == SP_FULL) begin
                                    err   <= 1'b1;
                                    state <= S_IDLE;
                                    pc    <= '0;
                                    ready <= 1'b1;
                                end else begin
                                    sp <= sp + SP_ONE;
                                    pc <= f_imm;
                                end
                            end
                            OP_RET: begin
                                if (sp == '0) begin
                                    err   <= 1'b1;
                                    state <= S_IDLE;
                                    pc    <= '0;
                                    ready <= 1'b1;
                                end else begin
                                    sp <= sp - SP_ONE;
                                    pc <= stack[sp - SP_ONE];
                                end
                            end
                            default: pc <= pc_inc;
                        endcase
                    end
                end
                default: begin
                    state <= S_IDLE;
                    pc    <= '0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_useq_engine.sv
// Directed testbench for useq_engine: small hand-written microprograms with
// hand-computed PC traces and status values.
module tb_useq_engine;

    localparam int PC_W = 8;
    localparam int IW   = 25;

    localparam logic [2:0] STEP  = 3'd0;
    localparam logic [2:0] WAITI = 3'd1;
    localparam logic [2:0] HALT  = 3'd2;
    localparam logic [2:0] JUMP  = 3'd3;
    localparam logic [2:0] LOOP  = 3'd4;
    localparam logic [2:0] LDCNT = 3'd5;
    localparam logic [2:0] CALL  = 3'd6;
    localparam logic [2:0] RET   = 3'd7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            continue_i = 1'b0;
    logic            abort_i = 1'b0;
    logic            rom_we = 1'b0;
    logic [PC_W-1:0] rom_waddr = '0;
    logic [IW-1:0]   rom_wdata = '0;
    logic [4:0]      ctl_a;
    logic [4:0]      ctl_b;
    logic [2:0]      ctl_op;
    logic [1:0]      ctl_d;
    logic [1:0]      ctl_e;
    logic            ready;
    logic            done;
    logic            err;
    logic [PC_W-1:0] pc_dbg;

    useq_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continue_i (continue_i),
        .abort_i    (abort_i),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .ctl_a      (ctl_a),
        .ctl_b      (ctl_b),
        .ctl_op     (ctl_op),
        .ctl_d      (ctl_d),
        .ctl_e      (ctl_e),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .pc_dbg     (pc_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] ins(input logic [4:0] a, input logic [4:0] b,
                                          input logic [2:0] op, input logic [1:0] d,
                                          input logic [1:0] e, input logic [7:0] imm);
        return {a, b, op, d, e, imm};
    endfunction

    task automatic load(input logic [PC_W-1:0] addr, input logic [IW-1:0] data);
        rom_we    = 1'b1;
        rom_waddr = addr;
        rom_wdata = data;
        step();
        rom_we    = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Walk a run, checking pc_dbg against the expected trace each cycle.
    task automatic trace(input string tag, input int n, input logic [7:0] exp_pc [16]);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_pc%0d", tag, i), 32'(pc_dbg), 32'(exp_pc[i]));
            step();
        end
    endtask

    logic [7:0] tr [16];
    int         body_visits;

    initial begin
        // ---- reset ----
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_ready", 32'(ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_pc", 32'(pc_dbg), 0);
        check("rst_ctl_a", 32'(ctl_a), 0);

        // ---- 1: STEP / WAIT / HALT ----
        load(8'd0, ins(5'd1, 5'd2, STEP, 2'd2, 2'd1, 8'd0));
        load(8'd1, ins(5'd3, 5'd0, WAITI, 2'd0, 2'd0, 8'd0));
        load(8'd2, ins(5'd0, 5'd0, STEP, 2'd0, 2'd0, 8'd0));
        load(8'd3, ins(5'd0, 5'd0, HALT, 2'd0, 2'd0, 8'd0));
        do_start();
        check("t1_ready_low", 32'(ready), 0);
        check("t1_ctl_a", 32'(ctl_a), 1);
        check("t1_ctl_b", 32'(ctl_b), 2);
        check("t1_ctl_d", 32'(ctl_d), 2);
        check("t1_ctl_e", 32'(ctl_e), 1);
        check("t1_ctl_op0", 32'(ctl_op), 32'(STEP));
        step();
        check("t1_pc_wait", 32'(pc_dbg), 1);
        check("t1_ctl_a_wait", 32'(ctl_a), 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t1_hold%0d", i), 32'(pc_dbg), 1);
        end
        continue_i = 1'b1;
        step();
        continue_i = 1'b0;
        check("t1_pc2", 32'(pc_dbg), 2);
        step();
        check("t1_pc3", 32'(pc_dbg), 3);
        check("t1_op_halt", 32'(ctl_op), 32'(HALT));
        step();
        check("t1_done", 32'(done), 1);
        check("t1_ready", 32'(ready), 1);
        check("t1_pc0", 32'(pc_dbg), 0);
        check("t1_ctl_a_idle", 32'(ctl_a), 0);
        step();
        check("t1_done_once", 32'(done), 0);

        // ---- 2: LDCNT / LOOP ----
        load(8'd0, ins(5'd0, 5'd0, LDCNT, 2'd0, 2'd0, 8'd2));
        load(8'd1, ins(5'd0, 5'd0, STEP, 2'd0, 2'd0, 8'd0));
        load(8'd2, ins(5'd0, 5'd0, LOOP, 2'd0, 2'd0, 8'd1));
        load(8'd3, ins(5'd0, 5'd0, HALT, 2'd0, 2'd0, 8'd0));
        do_start();
        tr = '{0, 1, 2, 1, 2, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        body_visits = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_pc%0d", i), 32'(pc_dbg), 32'(tr[i]));
            if (pc_dbg == 8'd1) body_visits++;
            check($sformatf("t2_run%0d", i), 32'(ready), 0);
            step();
        end
        check("t2_body_visits", 32'(body_visits), 3);
        check("t2_done", 32'(done), 1);
        check("t2_ready", 32'(ready), 1);

        // ---- 3: CALL / RET ----
        load(8'd0, ins(5'd0, 5'd0, CALL, 2'd0, 2'd0, 8'd10));
        load(8'd1, ins(5'd0, 5'd0, HALT, 2'd0, 2'd0, 8'd0));
        load(8'd10, ins(5'd0, 5'd0, STEP, 2'd0, 2'd0, 8'd0));
        load(8'd11, ins(5'd0, 5'd0, RET, 2'd0, 2'd0, 8'd0));
        do_start();
        tr = '{0, 10, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        trace("t3", 4, tr);
        check("t3_done", 32'(done), 1);
        check("t3_err", 32'(err), 0);

        // ---- JUMP with wraparound, then abort from a free-running loop ----
        load(8'd0, ins(5'd0, 5'd0, JUMP, 2'd0, 2'd0, 8'd254));
        load(8'd254, ins(5'd0, 5'd0, STEP, 2'd0, 2'd0, 8'd0));
        load(8'd255, ins(5'd7, 5'd0, STEP, 2'd0, 2'd0, 8'd0));
        do_start();
        tr = '{0, 254, 255, 0, 254, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        trace("tj", 5, tr);
        check("tj_pc255", 32'(pc_dbg), 255);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("tj_abort_ready", 32'(ready), 1);
        check("tj_abort_pc", 32'(pc_dbg), 0);
        check("tj_abort_done", 32'(done), 0);

        // ---- 4: stack overflow ----
        load(8'd0, ins(5'd0, 5'd0, CALL, 2'd0, 2'd0, 8'd0));
        do_start();
        for (int i = 0; i < 4; i++) step();
        check("t4_err_before", 32'(err), 0);
        check("t4_ready_before", 32'(ready), 0);
        step();
        check("t4_err", 32'(err), 1);
        check("t4_ready", 32'(ready), 1);
        check("t4_done", 32'(done), 0);
        check("t4_pc", 32'(pc_dbg), 0);
        step();
        check("t4_err_sticky", 32'(err), 1);
        do_start();
        check("t4_err_cleared", 32'(err), 0);
        check("t4_restart", 32'(ready), 0);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;

        // ---- 5: stack underflow ----
        load(8'd0, ins(5'd0, 5'd0, RET, 2'd0, 2'd0, 8'd0));
        do_start();
        step();
        check("t5_err", 32'(err), 1);
        check("t5_ready", 32'(ready), 1);
        check("t5_done", 32'(done), 0);

        // ---- 6: abort on WAIT, ignored writes, start+abort, reset mid-run ----
        load(8'd0, ins(5'd0, 5'd0, STEP, 2'd0, 2'd0, 8'd0));
        load(8'd1, ins(5'd3, 5'd0, WAITI, 2'd0, 2'd0, 8'd0));
        load(8'd2, ins(5'd0, 5'd0, STEP, 2'd0, 2'd0, 8'd0));
        load(8'd3, ins(5'd0, 5'd0, HALT, 2'd0, 2'd0, 8'd0));
        do_start();
        check("t6_err_cleared", 32'(err), 0);
        step();
        check("t6_parked", 32'(pc_dbg), 1);
        load(8'd3, ins(5'd31, 5'd0, STEP, 2'd0, 2'd0, 8'd0));
        check("t6_still_parked", 32'(pc_dbg), 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("t6_abort_ready", 32'(ready), 1);
        check("t6_abort_pc", 32'(pc_dbg), 0);
        check("t6_abort_done", 32'(done), 0);
        start   = 1'b1;
        abort_i = 1'b1;
        step();
        start   = 1'b0;
        abort_i = 1'b0;
        check("t6_start_abort_idle", 32'(ready), 1);
        continue_i = 1'b1;
        do_start();
        step();
        step();
        step();
        continue_i = 1'b0;
        check("t6_pc3", 32'(pc_dbg), 3);
        check("t6_word3_op", 32'(ctl_op), 32'(HALT));
        check("t6_word3_a", 32'(ctl_a), 0);
        step();
        check("t6_halt_done", 32'(done), 1);
        do_start();
        step();
        check("t6_mid_pc", 32'(pc_dbg), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_rst_ready", 32'(ready), 1);
        check("t6_rst_pc", 32'(pc_dbg), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_err", 32'(err), 0);
        check("t6_rst_ctl_a", 32'(ctl_a), 0);

        // ---- report ----
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: guarantees termination even if the sequence above stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
